pipe_stage_elastic: RTL

PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

---
 rtl/pipe_stage_elastic.sv | 103 ++++++++++
 1 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic valid/ready pipeline stage: 2-entry skid buffer (registered in_ready) or 1-entry stage.
// Latency 1 cycle accept->out_valid; flush discards held entries; stall_count saturates.
`timescale 1ns/1ps
module pipe_stage_elastic #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    SKID        = 1,
  parameter logic [DATA_WIDTH-1:0] FLUSH_VALUE = '0,
  parameter int                    COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  input  logic                   out_ready,
  output logic [COUNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  main_q, main_d;
  logic [DATA_WIDTH-1:0]  skid_q, skid_d;
  logic [COUNT_WIDTH-1:0] stall_q;
  logic                   accept;
  logic                   consume;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      if (out_valid && !out_ready && (stall_q != {COUNT_WIDTH{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  always_comb begin
    out_valid = (state_q != EMPTY);
    // SKID=0 passes out_ready straight through so the single entry can refill while draining
    if (SKID != 0) begin
      in_ready = (state_q != FULL);
    end else begin
      in_ready = !out_valid || out_ready;
    end
    accept  = in_valid && in_ready;
    consume = out_valid && out_ready;
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = FLUSH_VALUE;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = BUSY;
            main_d  = in_data;
          end
        end
        BUSY: begin
          if (accept && consume) begin
            main_d = in_data;
          end else if (accept && (SKID != 0)) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (consume) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            state_d = BUSY;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign out_data    = main_q;
  assign stall_count = stall_q;

endmodule
